// File: rtl/axi4l_sys_bus_bridge.sv
// AXI4-Lite slave to single-cycle-strobe system-bus master bridge.
// One transaction in flight; alternating read/write priority and a bus response timeout.
module axi4l_sys_bus_bridge #(
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int TMO = 255
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [AW-1:0]   awaddr,
   input  logic            awvalid,
   output logic            awready,
   input  logic [DW-1:0]   wdata,
   input  logic [DW/8-1:0] wstrb,
   input  logic            wvalid,
   output logic            wready,
   output logic [1:0]      bresp,
   output logic            bvalid,
   input  logic            bready,
   input  logic [AW-1:0]   araddr,
   input  logic            arvalid,
   output logic            arready,
   output logic [DW-1:0]   rdata,
   output logic [1:0]      rresp,
   output logic            rvalid,
   input  logic            rready,
   output logic            bus_wen,
   output logic            bus_ren,
   output logic [AW-1:0]   bus_addr,
   output logic [DW-1:0]   bus_wdata,
   input  logic [DW-1:0]   bus_rdata,
   input  logic            bus_ack,
   input  logic            bus_err
);

   localparam logic [2:0]  IDLE = 3'd0;
   localparam logic [2:0]  WBUS = 3'd1;
   localparam logic [2:0]  BRSP = 3'd2;
   localparam logic [2:0]  RBUS = 3'd3;
   localparam logic [2:0]  RRSP = 3'd4;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   // Counter value seen in the last permitted wait cycle (the strobe cycle counts as the first).
   localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

   logic [2:0]    state_q, state_d;
   logic          bus_wen_q, bus_wen_d;
   logic          bus_ren_q, bus_ren_d;
   logic [AW-1:0] bus_addr_q, bus_addr_d;
   logic [DW-1:0] bus_wdata_q, bus_wdata_d;
   logic [1:0]    bresp_q, bresp_d;
   logic [1:0]    rresp_q, rresp_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          bvalid_q, bvalid_d;
   logic          rvalid_q, rvalid_d;
   logic          last_wr_q, last_wr_d;
   logic [15:0]   tmo_cnt_q, tmo_cnt_d;

   logic          wr_req, rd_req, grant_wr, grant_rd;
   logic          bus_done;
   logic [1:0]    bus_code;

   // A pending request of one type wins outright; a tie goes to the type not served last.
   always_comb begin
      wr_req   = awvalid & wvalid;
      rd_req   = arvalid;
      grant_wr = (state_q == IDLE) && wr_req && (!rd_req || !last_wr_q);
      grant_rd = (state_q == IDLE) && rd_req && (!wr_req || last_wr_q);
      bus_done = bus_ack | bus_err | (tmo_cnt_q == TMO_LAST);
      bus_code = (bus_err | ~bus_ack) ? RESP_SLVERR : RESP_OKAY;
   end

   assign awready   = grant_wr;
   assign wready    = grant_wr;
   assign arready   = grant_rd;
   assign bus_wen   = bus_wen_q;
   assign bus_ren   = bus_ren_q;
   assign bus_addr  = bus_addr_q;
   assign bus_wdata = bus_wdata_q;
   assign bresp     = bresp_q;
   assign rresp     = rresp_q;
   assign rdata     = rdata_q;
   assign bvalid    = bvalid_q;
   assign rvalid    = rvalid_q;

   always_comb begin
      // NOTE: every signal is given a default before the case so no latch can be inferred.
      state_d     = state_q;
      bus_wen_d   = 1'b0;
      bus_ren_d   = 1'b0;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bresp_d     = bresp_q;
      rresp_d     = rresp_q;
      rdata_d     = rdata_q;
      bvalid_d    = bvalid_q;
      rvalid_d    = rvalid_q;
      last_wr_d   = last_wr_q;
      tmo_cnt_d   = tmo_cnt_q;

      case (state_q)
         IDLE: begin
            if (grant_wr) begin
               last_wr_d   = 1'b1;
               bus_addr_d  = awaddr;
               bus_wdata_d = wdata;
               tmo_cnt_d   = '0;
               if (&wstrb) begin
                  bus_wen_d = 1'b1;
                  state_d   = WBUS;
               end else begin
                  // Partial writes are refused without touching the bus.
                  bresp_d  = RESP_SLVERR;
                  bvalid_d = 1'b1;
                  state_d  = BRSP;
               end
            end else if (grant_rd) begin
               last_wr_d  = 1'b0;
               bus_addr_d = araddr;
               bus_ren_d  = 1'b1;
               tmo_cnt_d  = '0;
               state_d    = RBUS;
            end
         end
         WBUS: begin
            if (bus_done) begin
               bresp_d  = bus_code;
               bvalid_d = 1'b1;
               state_d  = BRSP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         RBUS: begin
            if (bus_done) begin
               rresp_d  = bus_code;
               rdata_d  = (bus_ack & ~bus_err) ? bus_rdata : '0;
               rvalid_d = 1'b1;
               state_d  = RRSP;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         BRSP: begin
            if (bready) begin
               bvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         RRSP: begin
            if (rready) begin
               rvalid_d = 1'b0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers update only with non-blocking assignments so all flops sample the same cycle's values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         bus_wen_q   <= 1'b0;
         bus_ren_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bresp_q     <= RESP_OKAY;
         rresp_q     <= RESP_OKAY;
         rdata_q     <= '0;
         bvalid_q    <= 1'b0;
         rvalid_q    <= 1'b0;
         last_wr_q   <= 1'b1;
         tmo_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         bus_wen_q   <= bus_wen_d;
         bus_ren_q   <= bus_ren_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bresp_q     <= bresp_d;
         rresp_q     <= rresp_d;
         rdata_q     <= rdata_d;
         bvalid_q    <= bvalid_d;
         rvalid_q    <= rvalid_d;
         last_wr_q   <= last_wr_d;
         tmo_cnt_q   <= tmo_cnt_d;
      end
   end

endmodule

// File: tb/tb_axi4l_sys_bus_bridge.sv
// Scoreboard bench for axi4l_sys_bus_bridge: stimulus pushes expected bus strobes and
// responses; a bus responder and a response monitor pop and compare independently.
module tb_axi4l_sys_bus_bridge;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int TMO = 8;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic          clk, rstn;
   logic [AW-1:0] awaddr, araddr;
   logic          awvalid, awready, wvalid, wready, arvalid, arready;
   logic [DW-1:0] wdata, rdata;
   logic [3:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          bvalid, bready, rvalid, rready;
   logic          bus_wen, bus_ren, bus_ack, bus_err;
   logic [AW-1:0] bus_addr;
   logic [DW-1:0] bus_wdata, bus_rdata;

   // Expected bus access plus how the bench's bus slave will answer it (d<0: never).
   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          d;
      bit          err;
      bit          ack_too;
      logic [31:0] rdata;
   } bus_exp_t;

   typedef struct {
      bit          wr;
      logic [1:0]  resp;
      logic [31:0] data;
   } rsp_exp_t;

   bus_exp_t bus_q[$];
   rsp_exp_t rsp_q[$];
   int       errors = 0;
   int       checks = 0;
   int       rdy_mode = 0;

   axi4l_sys_bus_bridge #(.DW(DW), .AW(AW), .TMO(TMO)) dut (
      .clk(clk), .rstn(rstn),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a response follows only from the strobe mask and the slave's answer timing.
   function automatic rsp_exp_t model(input bit wr, input logic [3:0] strb, input int d,
                                      input bit err, input logic [31:0] rd);
      rsp_exp_t r;
      r.wr   = wr;
      r.resp = OKAY;
      r.data = '0;
      if (wr && strb != 4'hF)                 r.resp = SLVERR;
      else if (d < 0 || d >= TMO || err)      r.resp = SLVERR;
      else if (!wr)                           r.data = rd;
      return r;
   endfunction

   // Bus slave: checks each strobe against the expectation queue and answers d cycles later.
   initial begin
      int       pend;
      bit       prev_strobe;
      bus_exp_t cur;
      pend = -1;
      prev_strobe = 1'b0;
      bus_ack = 1'b0;
      bus_err = 1'b0;
      bus_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            pend = -1;
            prev_strobe = 1'b0;
            bus_ack = 1'b0;
            bus_err = 1'b0;
         end else begin
            bus_ack = 1'b0;
            bus_err = 1'b0;
            bus_rdata = $urandom;
            if (bus_wen || bus_ren) begin
               check("strobe_one_cycle", prev_strobe, 0);
               if (bus_q.size() == 0) begin
                  check("unexpected_strobe", {bus_wen, bus_ren}, 0);
               end else begin
                  cur = bus_q.pop_front();
                  check("strobe_kind", {bus_wen, bus_ren}, cur.wr ? 2'b10 : 2'b01);
                  check("bus_addr", bus_addr, cur.addr);
                  if (cur.wr) check("bus_wdata", bus_wdata, cur.wdata);
                  pend = cur.d;
               end
            end
            prev_strobe = bus_wen | bus_ren;
            if (pend == 0) begin
               bus_ack = cur.err ? cur.ack_too : 1'b1;
               bus_err = cur.err;
               if (!cur.err) bus_rdata = cur.rdata;
               pend = -1;
            end else if (pend > 0) begin
               pend--;
            end
         end
      end
   end

   // Response monitor: pops on every B/R handshake and checks valid/data hold under backpressure.
   initial begin
      bit         b_wait, r_wait;
      logic [1:0] b_prev, r_prev_resp;
      logic [31:0] r_prev_data;
      rsp_exp_t   e;
      b_wait = 1'b0;
      r_wait = 1'b0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            b_wait = 1'b0;
            r_wait = 1'b0;
         end else begin
            if (b_wait) check("bvalid_hold", {bvalid, bresp}, {1'b1, b_prev});
            if (r_wait) check("rvalid_hold", {rvalid, rresp, rdata}, {1'b1, r_prev_resp, r_prev_data});
            if (bvalid && bready) begin
               if (rsp_q.size() == 0) check("unexpected_b", bvalid, 0);
               else begin
                  e = rsp_q.pop_front();
                  check("b_is_write", e.wr, 1);
                  check("bresp", bresp, e.resp);
               end
            end
            if (rvalid && rready) begin
               if (rsp_q.size() == 0) check("unexpected_r", rvalid, 0);
               else begin
                  e = rsp_q.pop_front();
                  check("r_is_read", e.wr, 0);
                  check("rresp", rresp, e.resp);
                  check("rdata", rdata, e.data);
               end
            end
            b_wait = bvalid & ~bready;
            r_wait = rvalid & ~rready;
            b_prev = bresp;
            r_prev_resp = rresp;
            r_prev_data = rdata;
         end
      end
   end

   // Response-channel ready: 0 always high, 1 random, otherwise held low.
   initial begin
      bready = 1'b0;
      rready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       {bready, rready} = 2'b11;
            1:       begin bready = $urandom_range(1, 0); rready = $urandom_range(1, 0); end
            default: {bready, rready} = 2'b00;
         endcase
      end
   end

   task automatic rst_checks();
      check("rst_valids", {bvalid, rvalid, bus_wen, bus_ren}, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_rdata", rdata, 0);
      check("rst_resp", {bresp, rresp}, 0);
      check("rst_readies", {awready, wready, arready}, 0);
   endtask

   // Entered and left at posedge+1.
   task automatic do_reset();
      rstn = 1'b0;
      rsp_q.delete();
      bus_q.delete();
      @(negedge clk);
      rst_checks();
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Issue one transaction and return at posedge+1 just after its address handshake.
   task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int d, input bit err, input bit ack_too,
                        input logic [31:0] rd);
      bus_exp_t b;
      bit       hs;
      hs = 1'b0;
      rsp_q.push_back(model(wr, strb, d, err, rd));
      if (!wr || strb == 4'hF) begin
         b = '{wr, addr, data, d, err, ack_too, rd};
         bus_q.push_back(b);
      end
      if (wr) begin
         awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
      end else begin
         araddr = addr; arvalid = 1'b1;
      end
      for (int i = 0; i < 50 && !hs; i++) begin
         @(negedge clk);
         if (wr ? (awready && wready) : arready) begin
            @(posedge clk);
            #1;
            hs = 1'b1;
         end
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check(wr ? "aw_w_handshake" : "ar_handshake", hs, 1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && rsp_q.size() != 0; i++) @(negedge clk);
      check("responses_drained", rsp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rvalid(output int n);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n++;
         if (rvalid) break;
      end
   endtask

   initial begin
      int         n;
      logic [7:0] grant_log;
      int         grants;
      bit         wr;
      logic [3:0] strb;
      int         d;

      rstn = 1'b0;
      awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0;
      araddr = '0; arvalid = 1'b0;
      repeat (2) @(negedge clk);
      rst_checks();
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Full write, ack in the strobe cycle: one-cycle strobe, bvalid the next cycle.
      rdy_mode = 0;
      issue(1, 32'h40, 32'h1234_5678, 4'hF, 0, 0, 0, 0);
      @(negedge clk);
      check("wen_in_first_cycle", bus_wen, 1);
      @(negedge clk);
      check("bvalid_next_cycle", {bvalid, bresp}, {1'b1, OKAY});
      wait_drain();

      // Read with ack three cycles after the strobe, response held while rready is low.
      rdy_mode = 2;
      @(posedge clk);
      #1;
      issue(0, 32'h80, 0, 4'hF, 3, 0, 0, 32'hCAFE_F00D);
      wait_rvalid(n);
      check("rvalid_latency", n, 5);
      for (int i = 0; i < 4; i++) begin
         check("rvalid_held", {rvalid, rresp, rdata}, {1'b1, OKAY, 32'hCAFE_F00D});
         if (i < 3) @(negedge clk);
      end
      rdy_mode = 0;
      wait_drain();

      // Partial strobe: no bus access, SLVERR.
      issue(1, 32'h44, 32'hDEAD_BEEF, 4'h3, 0, 0, 0, 0);
      wait_drain();

      // Read with no answer within TMO cycles; the late ack must change nothing.
      issue(0, 32'h88, 0, 4'hF, TMO + 2, 0, 0, 32'h5555_AAAA);
      wait_rvalid(n);
      check("timeout_latency", n, TMO + 1);
      repeat (4) @(negedge clk);
      check("late_ack_ignored", {bvalid, rvalid, bus_wen, bus_ren}, 0);
      wait_drain();

      // Simultaneous requests from reset: reads and writes alternate, read first.
      do_reset();
      for (int k = 0; k < 2; k++) begin
         rsp_q.push_back(model(0, 4'hF, 0, 0, 32'h1111_0000 + k));
         bus_q.push_back('{1'b0, 32'h100, 32'h0, 0, 1'b0, 1'b0, 32'h1111_0000 + k});
         rsp_q.push_back(model(1, 4'hF, 0, 0, 0));
         bus_q.push_back('{1'b1, 32'h200, 32'h5A5A_0001, 0, 1'b0, 1'b0, 32'h0});
      end
      awaddr = 32'h200; wdata = 32'h5A5A_0001; wstrb = 4'hF; araddr = 32'h100;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
      grant_log = '0;
      grants = 0;
      for (int i = 0; i < 200 && grants < 4; i++) begin
         @(negedge clk);
         if (arready) begin grant_log = {grant_log[5:0], 2'b01}; grants++; end
         if (awready) begin grant_log = {grant_log[5:0], 2'b10}; grants++; end
         @(posedge clk);
         #1;
      end
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("grant_count", grants, 4);
      check("grant_order_rwrw", grant_log, 8'b01_10_01_10);
      wait_drain();

      // Reset while waiting on the bus: transaction abandoned, next read is normal.
      issue(0, 32'h300, 0, 4'hF, -1, 0, 0, 0);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("quiet_after_reset", {rvalid, bvalid, bus_ren, bus_wen}, 0);
      end
      @(posedge clk);
      #1;
      issue(0, 32'h304, 0, 4'hF, 1, 0, 0, 32'h600D_F00D);
      wait_drain();

      // Random mix against the reference model, with random response backpressure.
      rdy_mode = 1;
      for (int t = 0; t < 40; t++) begin
         wr   = $urandom_range(1, 0);
         strb = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'hF;
         d    = ($urandom_range(9, 0) == 0) ? -1 : int'($urandom_range(TMO + 2, 0));
         issue(wr, $urandom & 32'hFFFF_FFFC, $urandom, strb, d,
               $urandom_range(4, 0) == 0, $urandom_range(1, 0), $urandom);
         wait_drain();
      end
      rdy_mode = 0;
      repeat (3) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
